// File: rtl/bu2_pkg.sv
// Shared types and helpers for the Bu2Point operand feeder and its write-back twin.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bu2_pkg;

    localparam int BU2_BIT_SIZE = 60;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2,
        DRAIN = 2'd3
    } bu2_state_t;

    // Reverse the low w bits of v; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[w-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/bu2_pair_addr_gen.sv
// Cooley-Tukey pair enumerator: butterfly index c and stage s -> i0, i1 and twiddle address.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
// Ports: c (pair index), s (log2 half-span) -> i0, i1 (buffer indices), tw_addr (ROM address).
module bu2_pair_addr_gen #(
    parameter int LOG_N = 4
) (
    input  logic [LOG_N-1:0] c,
    input  logic [LOG_N-1:0] s,
    output logic [LOG_N-1:0] i0,
    output logic [LOG_N-1:0] i1,
    output logic [LOG_N-2:0] tw_addr
);

    logic [LOG_N-1:0] h;
    logic [LOG_N-1:0] j;
    logic [LOG_N-1:0] blk;

    always_comb begin
        h   = LOG_N'(1) << s;
        j   = c & (h - LOG_N'(1));
        // Group number shifted up past both halves of its span.
        blk = (c >> s) << (s + LOG_N'(1));
        i0  = blk | j;
        i1  = i0 + h;
        // j < h <= N/2, so its top bit is always zero and the narrowing is lossless.
        tw_addr = (LOG_N-1)'(j) << (LOG_N'(LOG_N - 1) - s);
    end

endmodule

// File: rtl/bu2_stage_feeder.sv
// Buffers one NTT stage (N words), then streams N/2 butterfly operand sets A0/A1/Y/q, one per clock.
// Latency: each pair appears 2 edges after its twiddle-address cycle; done marks the last pair.
// Backpressure: load side valid/ready (ready only in LOAD); issue side never stalls.
// Option: define BU2_FEED_BITREV_EN to store the load stream in bit-reversed order.
// Ports: clk/rstn; start, stage_log, q_in; in_valid/in_ready/in_data; tw_addr/tw_data;
//        out_valid, A0, A1, Y, q; busy, done, err.
module bu2_stage_feeder
    import bu2_pkg::*;
#(
    parameter int BIT_SIZE = BU2_BIT_SIZE,
    parameter int N        = 16,
    parameter int LOG_N    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [LOG_N-1:0]    stage_log,
    input  logic [BIT_SIZE-1:0] q_in,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIT_SIZE-1:0] in_data,
    output logic [LOG_N-2:0]    tw_addr,
    input  logic [BIT_SIZE-1:0] tw_data,
    output logic                out_valid,
    output logic [BIT_SIZE-1:0] A0,
    output logic [BIT_SIZE-1:0] A1,
    output logic [BIT_SIZE-1:0] Y,
    output logic [BIT_SIZE-1:0] q,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [LOG_N-1:0] C_LAST = LOG_N'(N/2 - 1);
    localparam logic [LOG_N:0]   W_LAST = (LOG_N+1)'(N - 1);

    bu2_state_t state, nxt;

    logic [LOG_N:0]     wcnt;
    logic [LOG_N-1:0]   c;
    logic [LOG_N-1:0]   s_q;
    logic [LOG_N-1:0]   widx;
    logic [LOG_N-1:0]   i0, i1;
    logic [LOG_N-2:0]   ag_tw;
    logic               stage_ok;
    logic               accept;

    logic [BIT_SIZE-1:0] mem [N];
    logic [BIT_SIZE-1:0] s1_a0, s1_a1;
    logic                s1_vld, s1_last;

    assign stage_ok = (stage_log <= LOG_N'(LOG_N - 1));
    assign accept   = (state == LOAD) && in_valid;

    bu2_pair_addr_gen #(.LOG_N(LOG_N)) u_addr (
        .c       (c),
        .s       (s_q),
        .i0      (i0),
        .i1      (i1),
        .tw_addr (ag_tw)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= nxt;
    end

    // Next-state logic; DRAIN lasts two cycles so done lands on the final out_valid.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start && stage_ok)          nxt = LOAD;
            LOAD:    if (accept && wcnt == W_LAST)   nxt = ISSUE;
            ISSUE:   if (c == C_LAST)                nxt = DRAIN;
            DRAIN:   if (c == LOG_N'(1))             nxt = IDLE;
            default:                                 nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = (state == LOAD);
        busy     = (state != IDLE);
        tw_addr  = (state == ISSUE) ? ag_tw : '0;
    end

    // Counters and per-stage latches. c doubles as the DRAIN cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt <= '0;
            c    <= '0;
            s_q  <= '0;
            q    <= '0;
            err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (stage_ok) begin
                            s_q  <= stage_log;
                            q    <= q_in;
                            err  <= 1'b0;
                            wcnt <= '0;
                            c    <= '0;
                        end else begin
                            err  <= 1'b1;
                        end
                    end
                end
                LOAD:  if (accept) wcnt <= wcnt + (LOG_N+1)'(1);
                ISSUE: c <= (c == C_LAST) ? '0 : c + LOG_N'(1);
                DRAIN: c <= (c == LOG_N'(1)) ? '0 : c + LOG_N'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
`ifdef BU2_FEED_BITREV_EN
        widx = LOG_N'(bitrev(32'(wcnt[LOG_N-1:0]), LOG_N));
`else
        widx = wcnt[LOG_N-1:0];
`endif
    end

    // Coefficient store; contents are meaningless until a full load completes.
    always_ff @(posedge clk) begin
        if (accept) mem[widx] <= in_data;
    end

    // Two-stage operand pipeline: stage 1 reads the buffer while the ROM looks up
    // the twiddle, stage 2 joins both so A0/A1/Y leave together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            s1_a0     <= '0;
            s1_a1     <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            A0        <= '0;
            A1        <= '0;
            Y         <= '0;
        end else begin
            s1_vld  <= (state == ISSUE);
            s1_last <= (state == ISSUE) && (c == C_LAST);
            if (state == ISSUE) begin
                s1_a0 <= mem[i0];
                s1_a1 <= mem[i1];
            end
            out_valid <= s1_vld;
            done      <= s1_vld && s1_last;
            if (s1_vld) begin
                A0 <= s1_a0;
                A1 <= s1_a1;
                Y  <= tw_data;
            end
        end
    end

endmodule
